// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parameterised UART receiver. It has a 2-flop input
//               synchroniser, mid-bit sampling, optional parity, frame-error
//               and break detection, and a valid/ready output holding
//               register with overrun reporting.
//               Optional feature: define UART_RX_MAJORITY_EN to take each
//               bit as the 2-of-3 majority of samples around mid-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_HALF     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_LAST_BIT = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_PARITY     = 3'd3;
    localparam logic [2:0] S_STOP       = 3'd4;
    localparam logic [2:0] S_BREAK_WAIT = 3'd5;

    logic                 r_sync1;
    logic                 r_rx_sync;
    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 w_tick;
    logic                 w_bit;
    logic                 w_shift_en;
    logic                 w_par_en;
    logic                 w_load;
    logic                 w_par_x;
    logic                 w_par_err;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] c_HALF_M1 = c_HALF - CNT_W'(1);
    localparam logic [CNT_W-1:0] c_HALF_P1 = c_HALF + CNT_W'(1);

    logic r_maj_a;
    logic r_maj_b;

    // Capture the two early votes; the third is the live value at the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_maj_a <= 1'b1;
            r_maj_b <= 1'b1;
        end else begin
            if (r_cnt == c_HALF_M1) r_maj_a <= r_rx_sync;
            if (r_cnt == c_HALF)    r_maj_b <= r_rx_sync;
        end
    end

    assign w_tick = (r_cnt == c_HALF_P1);
    assign w_bit  = (r_maj_a & r_maj_b) | (r_maj_a & r_rx_sync) | (r_maj_b & r_rx_sync);
`else
    assign w_tick = (r_cnt == c_HALF);
    assign w_bit  = r_rx_sync;
`endif

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_rx_sync <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (!r_rx_sync) w_next_state = S_START;
            S_START:      if (w_tick) w_next_state = w_bit ? S_IDLE : S_DATA;
            S_DATA:       if (w_tick && (r_bit_idx == c_LAST_BIT))
                              w_next_state = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:     if (w_tick) w_next_state = S_STOP;
            S_STOP:       if (w_tick)
                              w_next_state = (!w_bit && (r_shift == '0)) ? S_BREAK_WAIT : S_IDLE;
            S_BREAK_WAIT: if (r_rx_sync) w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and per-state sample strobes.
    always_comb begin
        rx_busy    = (r_state != S_IDLE);
        w_shift_en = (r_state == S_DATA)   && w_tick;
        w_par_en   = (r_state == S_PARITY) && w_tick;
        w_load     = (r_state == S_STOP)   && w_tick;
    end

    // Bit-timing counter: held at 0 in IDLE so a start edge begins at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_cnt <= '0;
        else if (r_state == S_IDLE)  r_cnt <= '0;
        else if (r_cnt == c_LAST_CNT) r_cnt <= '0;
        else                         r_cnt <= r_cnt + CNT_W'(1);
    end

    // Data shift register (LSB first), bit index and captured parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
        end else begin
            if (r_state == S_START) r_bit_idx <= '0;
            if (w_shift_en) begin
                r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_par_en) r_par_bit <= w_bit;
        end
    end

    // Parity check over received data plus parity bit.
    always_comb begin
        w_par_x   = ^{r_shift, r_par_bit};
        w_par_err = 1'b0;
        case (PARITY)
            1:       w_par_err = w_par_x;
            2:       w_par_err = ~w_par_x;
            default: w_par_err = 1'b0;
        endcase
    end

    // Output holding register: load on stop sample, clear on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_rx    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_load) begin
            data_rx    <= r_shift;
            rx_valid   <= 1'b1;
            parity_err <= w_par_err;
            frame_err  <= ~w_bit;
            overrun    <= rx_valid & ~rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
`default_nettype wire
